vector_write_sequencer: RTL and testbench
=========================================

Name: vector_write_sequencer

Overview:
Sequential write-address generator for the vector memory write path. On `start` it issues either one scalar write or a strided burst of `vlen` element writes, stalling on memory back-pressure. It pulses `write_done` when the last element is accepted. Sits between the execute-stage vector unit, which supplies element data indexed by `elem_idx`, and the data-memory write port.

Parameters:
ADDR_WIDTH, 10, width of memory word address
STRIDE_WIDTH, 4, width of element stride (unsigned, in words)
VLEN_MAX, 20, maximum elements per vector write
LEN_WIDTH, 5, width of vlen/elem_idx; must satisfy 2**LEN_WIDTH > VLEN_MAX

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; synchronous and active-high
start  input  1  request a write operation; sampled only in IDLE
op_type  input  1  0 = scalar write, 1 = vector write
base_address  input  ADDR_WIDTH  address of element 0
stride  input  STRIDE_WIDTH  address increment between elements (vector only)
vlen  input  LEN_WIDTH  element count (vector only); values above VLEN_MAX are clamped to VLEN_MAX
mem_ready  input  1  memory accepts the current write this cycle
wr_en  output  1  write request valid
wr_address  output  ADDR_WIDTH  address of current write
elem_idx  output  LEN_WIDTH  index of element being written
busy  output  1  operation in progress
write_done  output  1  one-cycle pulse: operation finished

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (cycle after rst sampled high): state=IDLE, wr_en=0, wr_address=0, elem_idx=0, busy=0, write_done=0. All outputs are registered.
- Reset mid-operation: the burst aborts immediately, no done pulse, and state returns to IDLE.
- States: IDLE, WRITE, DONE.
- IDLE:
  - If start=1 and effective length > 0: latch base, stride, op_type and length, where length = 1 if op_type=0, else min(vlen, VLEN_MAX).
  - Next cycle: WRITE with wr_en=1, wr_address=base, elem_idx=0, busy=1.
  - If start=1, op_type=1 and vlen=0: go straight to DONE (no writes; busy=1 for that one cycle).
- WRITE:
  - A write is accepted in a cycle where wr_en=1 and mem_ready=1.
  - On acceptance of a non-last element: next cycle wr_address += stride, elem_idx += 1.
  - Without acceptance: wr_address and elem_idx hold, and wr_en stays 1.
  - On acceptance of the last element (elem_idx == length-1): next cycle DONE, wr_en=0.
- DONE: write_done=1 and busy=1 for exactly one cycle; next cycle IDLE with busy=0 and write_done=0.
- `start` is ignored in WRITE and DONE; it is not queued. The earliest new start is sampled in the first IDLE cycle.
- Address arithmetic is modulo 2**ADDR_WIDTH, so addresses wrap silently. stride=0 is legal and writes the same address `length` times.
- Scalar operation ignores stride and vlen.
- Latency from start to done:
  - With mem_ready held at 1: 1 + length + 1 cycles from the start-sample edge to the done cycle.
  - Each deasserted mem_ready cycle in WRITE adds one cycle.
- Inputs base_address, stride, vlen and op_type are captured at start; later changes have no effect on the running operation.

Test Plan:
- Scalar write:
  - Stimulus: base=573, op_type=0, start for 1 cycle, mem_ready=1.
  - Response: exactly one wr_en cycle at address 573 with elem_idx=0; write_done pulses the following cycle; busy is high for 2 cycles.
- Vector unit stride:
  - Stimulus: base=573, stride=1, vlen=20, mem_ready=1.
  - Response: 20 consecutive wr_en cycles at addresses 573..592 with elem_idx 0..19; write_done exactly one cycle after the write to 592; no write to 593.
- Back-pressure with wrap-around:
  - Stimulus: base=1020, stride=3, vlen=4; mem_ready low on the 2nd and 3rd WRITE cycles.
  - Response: addresses 1020, 1023, 2, 5 (each held while stalled); total 6 wr_en cycles; single done pulse.
- Edge lengths:
  - Stimulus (a): vector with vlen=0. Response: no wr_en; write_done pulses 1 cycle after start.
  - Stimulus (b): vector with vlen=31. Response: clamped to 20 writes.
- Start while busy:
  - Stimulus: assert a second start (base=100) during a burst.
  - Response: it is ignored, with no writes to 100. A start in the first IDLE cycle afterwards is accepted.
- Reset mid-burst:
  - Stimulus: assert rst at element 7 of a 20-element burst.
  - Response: next cycle all outputs are 0 and there is no write_done. A subsequent scalar start behaves as in the scalar-write scenario.

Source files
------------

// File: rtl/vector_write_sequencer_if.sv
// Bundle between the vector write sequencer and its environment: the request side
// (start/op/base/stride/vlen), memory back-pressure, and the generated write stream.
interface vector_write_sequencer_if #(
   parameter int ADDR_WIDTH   = 10,
   parameter int STRIDE_WIDTH = 4,
   parameter int LEN_WIDTH    = 5
);
   logic                    start;
   logic                    op_type;
   logic [ADDR_WIDTH-1:0]   base_address;
   logic [STRIDE_WIDTH-1:0] stride;
   logic [LEN_WIDTH-1:0]    vlen;
   logic                    mem_ready;
   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_address;
   logic [LEN_WIDTH-1:0]    elem_idx;
   logic                    busy;
   logic                    write_done;

   // master = execute stage plus memory port; slave = the sequencer itself
   modport master (
      output start, op_type, base_address, stride, vlen, mem_ready,
      input  wr_en, wr_address, elem_idx, busy, write_done
   );

   modport slave (
      input  start, op_type, base_address, stride, vlen, mem_ready,
      output wr_en, wr_address, elem_idx, busy, write_done
   );
endinterface

// File: rtl/vector_write_sequencer.sv
// Strided write-address generator: one scalar write or a burst of up to VLEN_MAX
// element writes, stalling on mem_ready, with a one-cycle write_done pulse at the end.
module vector_write_sequencer #(
   parameter int ADDR_WIDTH   = 10,
   parameter int STRIDE_WIDTH = 4,
   parameter int VLEN_MAX     = 20,
   parameter int LEN_WIDTH    = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   vector_write_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   localparam logic [LEN_WIDTH-1:0] VLEN_MAX_L = LEN_WIDTH'(VLEN_MAX);

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LEN_WIDTH-1:0]    idx_q, idx_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [STRIDE_WIDTH-1:0] stride_q;
   logic                    wr_en_q, busy_q, done_q;
   logic                    last_w;

   always_comb begin
      addr_d = addr_q + ADDR_WIDTH'(stride_q);
      idx_d  = idx_q + LEN_WIDTH'(1);
      // Scalar ops are always one element; vector lengths clamp to VLEN_MAX
      if (!bus.op_type)
         len_d = LEN_WIDTH'(1);
      else if (bus.vlen > VLEN_MAX_L)
         len_d = VLEN_MAX_L;
      else
         len_d = bus.vlen;
   end

   assign last_w = (idx_d == len_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               wr_en_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               if (bus.start) begin
                  busy_q   <= 1'b1;
                  len_q    <= len_d;
                  stride_q <= bus.stride;
                  if (len_d == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= WRITE;
                     wr_en_q <= 1'b1;
                     addr_q  <= bus.base_address;
                     idx_q   <= '0;
                  end
               end
            end
            WRITE: begin
               if (bus.mem_ready) begin
                  if (last_w) begin
                     state_q <= DONE;
                     wr_en_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     addr_q <= addr_d;
                     idx_q  <= idx_d;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               wr_en_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.wr_address = addr_q;
   assign bus.elem_idx   = idx_q;
   assign bus.busy       = busy_q;
   assign bus.write_done = done_q;

endmodule

// File: tb/tb_vector_write_sequencer.sv
// Bench for vector_write_sequencer: table of directed operations, reset corner cases,
// and randomized operations checked cycle by cycle against an address-list model.
module tb_vector_write_sequencer;

   localparam int AW = 10;
   localparam int SW = 4;
   localparam int VM = 20;
   localparam int LW = 5;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   vector_write_sequencer_if #(.ADDR_WIDTH(AW), .STRIDE_WIDTH(SW), .LEN_WIDTH(LW)) bus ();

   vector_write_sequencer #(
      .ADDR_WIDTH(AW), .STRIDE_WIDTH(SW), .VLEN_MAX(VM), .LEN_WIDTH(LW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drives one operation from the current negedge and follows it to the first IDLE
   // cycle. The model is the list of addresses base + i*stride (mod 2**AW), i < length.
   // mode: 0 = mem_ready always 1, 1 = random, 2 = mask bit k for k-th WRITE cycle.
   task automatic run_op(input bit op, input int base, input int stride, input int vlen,
                         input int mode, input logic [63:0] mask, input bit start_busy,
                         output int n_wr, output int n_acc, output int last_addr,
                         output int n_busy);
      int  len;
      int  k;
      bit  fin;
      bit  done_seen;
      bit  rdy;
      len = op ? ((vlen > VM) ? VM : vlen) : 1;
      bus.start        = 1'b1;
      bus.op_type      = op;
      bus.base_address = AW'(base);
      bus.stride       = SW'(stride);
      bus.vlen         = LW'(vlen);
      bus.mem_ready    = 1'b1;
      n_wr = 0; n_acc = 0; last_addr = -1; n_busy = 0;
      done_seen = 0; fin = 0; k = 0;
      @(negedge clk);
      bus.start        = 1'b0;
      bus.op_type      = 1'($urandom);
      bus.base_address = AW'($urandom);
      bus.stride       = SW'($urandom);
      bus.vlen         = LW'($urandom);
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         if (bus.busy) n_busy++;
         if (done_seen) begin
            chk("idle_busy",  bus.busy, 0);
            chk("idle_done",  bus.write_done, 0);
            chk("idle_wr_en", bus.wr_en, 0);
            fin = 1;
         end else if (n_acc < len) begin
            chk("wr_en",      bus.wr_en, 1);
            chk("busy",       bus.busy, 1);
            chk("early_done", bus.write_done, 0);
            chk("wr_address", bus.wr_address, (base + n_acc * stride) % (1 << AW));
            chk("elem_idx",   bus.elem_idx, n_acc);
            n_wr++;
            last_addr = int'(bus.wr_address);
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            else                rdy = mask[k[5:0]];
            k++;
            bus.mem_ready = rdy;
            if (rdy) n_acc++;
            if (start_busy) begin
               bus.start        = 1'b1;
               bus.op_type      = 1'b1;
               bus.base_address = AW'(100);
               bus.vlen         = LW'(3);
            end
         end else begin
            chk("done_pulse", bus.write_done, 1);
            chk("done_busy",  bus.busy, 1);
            chk("done_wr_en", bus.wr_en, 0);
            done_seen = 1;
            bus.start = start_busy;
            bus.mem_ready = 1'($urandom);
         end
         if (!fin) @(negedge clk);
      end
      bus.start = 1'b0;
      if (!fin) chk("timeout_op_end", 0, 1);
   endtask

   typedef struct {
      string       name;
      bit          op;
      int          base;
      int          stride;
      int          vlen;
      int          mode;
      logic [63:0] mask;
      bit          start_busy;
      int          exp_wr;
      int          exp_acc;
      int          exp_last;
      int          exp_busy;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int  n_wr, n_acc, last_addr, n_busy;
      int  len;
      bit  found;

      vecs.push_back('{"scalar",      0, 573, 9, 13, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  1,  1, 573,  2});
      vecs.push_back('{"unit_stride", 1, 573, 1, 20, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 20, 20, 592, 21});
      vecs.push_back('{"bp_wrap",     1, 1020, 3, 4, 2, ~64'h6,                  0,  6,  4,   5,  7});
      vecs.push_back('{"vlen0",       1, 50,  2,  0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  0,  0,  -1,  1});
      vecs.push_back('{"vlen31",      1, 10,  2, 31, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 20, 20,  48, 21});
      vecs.push_back('{"start_busy",  1, 200, 5,  6, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1,  6,  6, 225,  7});
      vecs.push_back('{"first_idle",  0, 100, 3,  2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  1,  1, 100,  2});
      vecs.push_back('{"stride0",     1, 7,   0,  5, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  5,  5,   7,  6});
      vecs.push_back('{"wrap_long",   1, 1000, 15, 20, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 20, 20, 261, 21});

      rst = 1'b1;
      bus.start = 1'b0; bus.op_type = 1'b0; bus.base_address = '0;
      bus.stride = '0; bus.vlen = '0; bus.mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_wr_en",   bus.wr_en, 0);
      chk("rst_addr",    bus.wr_address, 0);
      chk("rst_idx",     bus.elem_idx, 0);
      chk("rst_busy",    bus.busy, 0);
      chk("rst_done",    bus.write_done, 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].base, vecs[i].stride, vecs[i].vlen, vecs[i].mode,
                vecs[i].mask, vecs[i].start_busy, n_wr, n_acc, last_addr, n_busy);
         chk({vecs[i].name, "_wr_cycles"},   n_wr, vecs[i].exp_wr);
         chk({vecs[i].name, "_accepted"},    n_acc, vecs[i].exp_acc);
         chk({vecs[i].name, "_last_addr"},   last_addr, vecs[i].exp_last);
         chk({vecs[i].name, "_busy_cycles"}, n_busy, vecs[i].exp_busy);
      end

      // Reset in the middle of a 20-element burst, at element 7
      bus.start = 1'b1; bus.op_type = 1'b1; bus.base_address = AW'(300);
      bus.stride = SW'(1); bus.vlen = LW'(20); bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (bus.wr_en && bus.elem_idx == LW'(7)) found = 1;
         else @(negedge clk);
      end
      chk("midrst_reach_elem7", found, 1);
      chk("midrst_addr_elem7",  bus.wr_address, 307);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_wr_en", bus.wr_en, 0);
      chk("midrst_addr",  bus.wr_address, 0);
      chk("midrst_idx",   bus.elem_idx, 0);
      chk("midrst_busy",  bus.busy, 0);
      chk("midrst_done",  bus.write_done, 0);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("postrst_done", bus.write_done, 0);
         chk("postrst_busy", bus.busy, 0);
      end
      run_op(0, 573, 4, 7, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, n_wr, n_acc, last_addr, n_busy);
      chk("postrst_scalar_wr",   n_wr, 1);
      chk("postrst_scalar_last", last_addr, 573);
      chk("postrst_scalar_busy", n_busy, 2);

      // Randomized operations under random back-pressure
      for (int t = 0; t < 40; t++) begin
         bit op;
         int base, stride, vlen;
         op     = 1'($urandom);
         base   = $urandom_range(0, (1 << AW) - 1);
         stride = $urandom_range(0, (1 << SW) - 1);
         vlen   = $urandom_range(0, (1 << LW) - 1);
         len    = op ? ((vlen > VM) ? VM : vlen) : 1;
         run_op(op, base, stride, vlen, 1, '0, t[0], n_wr, n_acc, last_addr, n_busy);
         chk("rand_accepted", n_acc, len);
         chk("rand_busy_cycles", n_busy, n_wr + 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
